// File: rtl/if_branch_predictor_pkg.sv
// Shared widths and 2-bit counter encodings for the IF-stage branch predictor.
package if_branch_predictor_pkg;

    localparam int WORD           = 32;
    localparam int DEF_INDEX_BITS = 6;
    localparam int DEF_TAG_BITS   = 8;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

endpackage

// File: rtl/if_branch_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating taken/not-taken counter.
module sat_counter2
    import if_branch_predictor_pkg::*;
(
    input  ctr_t ctr,
    input  logic taken,
    output ctr_t ctr_nxt
);

    always_comb begin
        ctr_nxt = ctr;
        unique case (ctr)
            SNT: ctr_nxt = taken ? WNT : SNT;
            WNT: ctr_nxt = taken ? WT  : SNT;
            WT:  ctr_nxt = taken ? ST  : WNT;
            ST:  ctr_nxt = taken ? ST  : WT;
            default: ctr_nxt = WNT;
        endcase
    end

endmodule

// File: rtl/if_branch_predictor.sv
// Direct-mapped 2-bit counter predictor with tagged targets, trained from EX.
module if_branch_predictor
    import if_branch_predictor_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int TAG_BITS   = DEF_TAG_BITS
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [WORD-1:0] PC_IF,
    output logic            predict,
    output logic [WORD-1:0] PC_Predict,
    input  logic            upd_valid,
    input  logic [WORD-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [WORD-1:0] upd_target,
    input  logic            upd_mispredict,
    output logic [31:0]     branch_cnt,
    output logic [31:0]     miss_cnt
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_LO  = INDEX_BITS + 2;
    localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [WORD-1:0]     target_q [ENTRIES];
    ctr_t                ctr_q    [ENTRIES];
    logic [31:0]         branch_cnt_q;
    logic [31:0]         miss_cnt_q;

    logic [INDEX_BITS-1:0] rd_idx;
    logic [TAG_BITS-1:0]   rd_tag;
    logic                  rd_hit;
    logic [INDEX_BITS-1:0] wr_idx;
    logic [TAG_BITS-1:0]   wr_tag;
    logic                  wr_hit;
    ctr_t                  sat_nxt;
    logic                  unused_pc;

    assign rd_idx = PC_IF[INDEX_BITS+1:2];
    assign rd_tag = PC_IF[TAG_HI:TAG_LO];
    assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

    assign predict    = rd_hit && ctr_q[rd_idx][1];
    assign PC_Predict = predict ? target_q[rd_idx] : PC_IF + WORD'(4);

    assign wr_idx = upd_pc[INDEX_BITS+1:2];
    assign wr_tag = upd_pc[TAG_HI:TAG_LO];
    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    assign unused_pc = ^{PC_IF[1:0], PC_IF[WORD-1:TAG_HI+1],
                         upd_pc[1:0], upd_pc[WORD-1:TAG_HI+1]};

    sat_counter2 u_sat (
        .ctr     (ctr_q[wr_idx]),
        .taken   (upd_taken),
        .ctr_nxt (sat_nxt)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= WNT;
            end
        end else if (upd_valid) begin
            valid_q[wr_idx] <= 1'b1;
            ctr_q[wr_idx]   <= wr_hit ? sat_nxt : (upd_taken ? WT : WNT);
        end
    end

    // Tags/targets need no clear: valid gates every use of them.
    always_ff @(posedge clk) begin
        if (rstn && upd_valid && (!wr_hit || upd_taken)) begin
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= upd_target;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else if (upd_valid) begin
            branch_cnt_q <= branch_cnt_q + 32'd1;
            if (upd_mispredict) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign branch_cnt = branch_cnt_q;
    assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_if_branch_predictor.sv
// Directed vector table plus hand sequences for the IF branch predictor.
module tb_if_branch_predictor;

    logic        clk;
    logic        rstn;
    logic [31:0] PC_IF;
    logic        predict;
    logic [31:0] PC_Predict;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
    logic [31:0] branch_cnt;
    logic [31:0] miss_cnt;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] A  = 32'h1C00_0010;
    localparam logic [31:0] B  = 32'h1C00_0110;
    localparam logic [31:0] T  = 32'h1C00_0100;
    localparam logic [31:0] T2 = 32'h1C00_0200;
    localparam logic [31:0] T3 = 32'h1C00_0300;
    localparam logic [31:0] T6 = 32'h1C00_0600;

    typedef struct {
        logic [31:0] pc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] tgt;
        logic        um;
        logic        ep;
        logic [31:0] epc;
        logic [31:0] eb;
        logic [31:0] em;
    } vec_t;

    vec_t vecs[18];

    if_branch_predictor dut (
        .clk            (clk),
        .rstn           (rstn),
        .PC_IF          (PC_IF),
        .predict        (predict),
        .PC_Predict     (PC_Predict),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_mispredict (upd_mispredict),
        .branch_cnt     (branch_cnt),
        .miss_cnt       (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic uv,
                         input logic [31:0] upc, input logic ut,
                         input logic [31:0] tgt, input logic um);
        PC_IF          = pc;
        upd_valid      = uv;
        upd_pc         = upc;
        upd_taken      = ut;
        upd_target     = tgt;
        upd_mispredict = um;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Expected outputs are sampled before the edge that applies the update.
        vecs[0]  = '{32'h1C00_0000, 0, 0, 0, 0,  0, 0, 32'h1C00_0004, 0, 0};
        vecs[1]  = '{A, 1, A, 1, T,  1, 0, 32'h1C00_0014, 0, 0};
        vecs[2]  = '{A, 1, A, 0, T,  1, 1, T,             1, 1};
        vecs[3]  = '{A, 1, A, 0, T,  0, 0, 32'h1C00_0014, 2, 2};
        vecs[4]  = '{A, 1, A, 1, T,  1, 0, 32'h1C00_0014, 3, 2};
        vecs[5]  = '{A, 1, A, 1, T,  1, 0, 32'h1C00_0014, 4, 3};
        vecs[6]  = '{A, 1, A, 1, T2, 0, 1, T,             5, 4};
        vecs[7]  = '{A, 1, A, 1, T2, 0, 1, T2,            6, 4};
        vecs[8]  = '{A, 1, A, 0, T3, 1, 1, T2,            7, 4};
        vecs[9]  = '{A, 0, 0, 0, 0,  0, 1, T2,            8, 5};
        vecs[10] = '{A, 1, B, 0, 32'h1C00_0500, 0, 1, T2, 8, 5};
        vecs[11] = '{A, 0, 0, 0, 0,  0, 0, 32'h1C00_0014, 9, 5};
        vecs[12] = '{B, 0, 0, 0, 0,  0, 0, 32'h1C00_0114, 9, 5};
        vecs[13] = '{32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 32'h0, 9, 5};
        vecs[14] = '{B, 0, B, 1, T6, 1, 0, 32'h1C00_0114, 9, 5};
        vecs[15] = '{B, 0, 0, 0, 0,  0, 0, 32'h1C00_0114, 9, 5};
        vecs[16] = '{B, 1, B, 1, T6, 0, 0, 32'h1C00_0114, 9, 5};
        vecs[17] = '{B, 0, 0, 0, 0,  0, 1, T6,           10, 5};

        rstn = 1'b0;
        drive(32'h1C00_0000, 0, 0, 0, 0, 0);
        tick();
        #1;
        chk("rst_predict", {31'd0, predict}, 32'd0);
        chk("rst_pcp", PC_Predict, 32'h1C00_0004);
        chk("rst_bcnt", branch_cnt, 32'd0);
        chk("rst_mcnt", miss_cnt, 32'd0);
        tick();
        rstn = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].pc, vecs[i].uv, vecs[i].upc,
                  vecs[i].ut, vecs[i].tgt, vecs[i].um);
            #1;
            chk($sformatf("v%0d_predict", i), {31'd0, predict},
                {31'd0, vecs[i].ep});
            chk($sformatf("v%0d_pcp", i), PC_Predict, vecs[i].epc);
            chk($sformatf("v%0d_bcnt", i), branch_cnt, vecs[i].eb);
            chk($sformatf("v%0d_mcnt", i), miss_cnt, vecs[i].em);
            tick();
        end

        // Reallocate A over B, train to ST, then lookup during a not-taken update.
        drive(A, 1, A, 1, T, 0);
        tick();
        drive(A, 1, A, 1, T, 0);
        tick();
        drive(A, 1, A, 0, T3, 1);
        #1;
        chk("haz_pre_predict", {31'd0, predict}, 32'd1);
        chk("haz_pre_pcp", PC_Predict, T);
        chk("haz_pre_mcnt", miss_cnt, 32'd5);
        tick();
        drive(A, 0, 0, 0, 0, 0);
        #1;
        chk("haz_post_predict", {31'd0, predict}, 32'd1);
        chk("haz_post_pcp", PC_Predict, T);
        chk("haz_post_bcnt", branch_cnt, 32'd13);
        chk("haz_post_mcnt", miss_cnt, 32'd6);

        // Asynchronous reset between edges while an update stream is live.
        drive(A, 1, A, 1, T, 1);
        #3;
        rstn = 1'b0;
        #1;
        chk("arst_predict", {31'd0, predict}, 32'd0);
        chk("arst_pcp", PC_Predict, 32'h1C00_0014);
        chk("arst_bcnt", branch_cnt, 32'd0);
        chk("arst_mcnt", miss_cnt, 32'd0);
        tick();
        tick();
        chk("arst_hold_bcnt", branch_cnt, 32'd0);
        rstn = 1'b1;
        drive(A, 0, 0, 0, 0, 0);
        #1;
        chk("post_rst_predict", {31'd0, predict}, 32'd0);
        chk("post_rst_pcp", PC_Predict, 32'h1C00_0014);
        drive(A, 1, A, 1, T2, 0);
        tick();
        drive(A, 0, 0, 0, 0, 0);
        #1;
        chk("first_upd_predict", {31'd0, predict}, 32'd1);
        chk("first_upd_pcp", PC_Predict, T2);
        chk("first_upd_bcnt", branch_cnt, 32'd1);

        // Counter wrap from all-ones.
        force dut.branch_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.branch_cnt_q;
        #1;
        chk("wrap_pre_bcnt", branch_cnt, 32'hFFFF_FFFF);
        drive(A, 1, A, 1, T2, 0);
        tick();
        drive(A, 0, 0, 0, 0, 0);
        #1;
        chk("wrap_bcnt", branch_cnt, 32'd0);
        chk("wrap_mcnt", miss_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
